// File: rtl/sequential_divider_pkg.sv
// Shared arithmetic-family package: FSM state encoding and the default datapath width.
package arith_seq_pkg;

  localparam int ARITH_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sequential_divider_if.sv
// Request/result bundle for sequential_divider; master issues operands, slave returns results.
interface sequential_divider_if
  import arith_seq_pkg::*;
#(
  parameter int W = ARITH_W
) ();

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/sequential_divider_div_step.sv
// One combinational radix-2 restoring iteration: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   r,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W:0]   r_next,
  output logic [W-1:0] q_next
);

  logic [W+1:0] r_sh;
  logic         fits;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    // r[W] is always 0 after a restoring step, so carrying it in the shift is harmless.
    r_sh   = {r, q[W-1]};
    fits   = (r_sh >= {2'b00, d});
    r_next = r_sh[W:0];
    if (fits) r_next = (W+1)'(r_sh - {2'b00, d});
    q_next = {q[W-2:0], fits};
  end

endmodule

// File: rtl/sequential_divider.sv
// Radix-2 restoring sequential divider, one quotient bit per clock, W-cycle latency.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module sequential_divider
  import arith_seq_pkg::*;
#(
  parameter int W = ARITH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  sequential_divider_if.slave bus
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  seq_state_e       state;
  logic [W:0]       r;
  logic [W-1:0]     q;
  logic [W-1:0]     d;
  logic [CNT_W-1:0] cnt;
  logic             dz_pend;

  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     quot_q;
  logic [W-1:0]     rem_q;
  logic             dbz_q;

  logic [W:0]       r_nxt;
  logic [W-1:0]     q_nxt;

  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;
  logic [W-1:0]     q_fix;
  logic [W-1:0]     r_fix;
  logic [W-1:0]     rem_dz;

  div_step #(.W(W)) u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    a_mag  = bus.dividend[W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag  = bus.divisor[W-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
    q_fix  = neg_q ? (~q_nxt + 1'b1) : q_nxt;
    r_fix  = neg_r ? (~r_nxt[W-1:0] + 1'b1) : r_nxt[W-1:0];
    // q still holds |dividend| on the zero-divisor path; re-apply its sign.
    rem_dz = neg_r ? (~q + 1'b1) : q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && !dz_pend && bus.start) begin
      neg_q <= bus.dividend[W-1] ^ bus.divisor[W-1];
      neg_r <= bus.dividend[W-1];
    end
  end
`else
  always_comb begin
    a_mag  = bus.dividend;
    b_mag  = bus.divisor;
    q_fix  = q_nxt;
    r_fix  = r_nxt[W-1:0];
    rem_dz = q;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      r       <= '0;
      q       <= '0;
      d       <= '0;
      cnt     <= '0;
      dz_pend <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dz_pend) begin
            // Zero divisor: spend the accept cycle idle so DONE lands one edge later.
            dz_pend <= 1'b0;
            state   <= DONE;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
            quot_q  <= '1;
            rem_q   <= rem_dz;
          end else if (bus.start) begin
            q      <= a_mag;
            d      <= b_mag;
            r      <= '0;
            cnt    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
            if (bus.divisor == '0) begin
              dz_pend <= 1'b1;
            end else begin
              state  <= CALC;
              busy_q <= 1'b1;
            end
          end
        end
        CALC: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            quot_q <= q_fix;
            rem_q  <= r_fix;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed-vector bench for sequential_divider at W=8; honours SEQ_DIV_SIGNED_EN.
module tb_sequential_divider;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  sequential_divider_if #(.W(W)) bus ();

  sequential_divider #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passes++;
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                         input logic exp_dz, input int exp_lat);
    int lat;
    int busy_cnt;
    bit got_done;
    bit overlap;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_cnt = 0; got_done = 0; overlap = 0;
    if (bus.busy) busy_cnt++;
    while (!got_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy && bus.done) overlap = 1;
      if (bus.done) got_done = 1;
      else if (bus.busy) busy_cnt++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_dz ? 0 : exp_lat);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_quotient"}, bus.quotient, exp_q);
    check({tag, "_remainder"}, bus.remainder, exp_r);
    check({tag, "_dbz"}, bus.div_by_zero, exp_dz);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int guard;
    checks = 0;
    passes = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    run_div("d55_0", 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 1);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
    run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);

    // Start pulses mid-CALC and during DONE must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.dividend = 8'd1; bus.divisor = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    guard = 0;
    while (!bus.done && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ign_done_seen", bus.done, 1);
    bus.start = 1'b1; bus.dividend = 8'd2; bus.divisor = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("ign_no_requeue", bus.busy, 0);
    check("ign_quotient", bus.quotient, 14);
    check("ign_remainder", bus.remainder, 2);

    // Reset at iteration 4 clears everything immediately.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
    run_div("d200_3", 8'd200, 8'd3, 8'hEE, 8'hFE, 1'b0, 8);
    run_div("dm7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 8);
    run_div("dm128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
    run_div("dm9_0", 8'hF7, 8'd0, 8'hFF, 8'hF7, 1'b1, 1);
`else
    run_div("d200_3", 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 8);
    run_div("d128_255", 8'd128, 8'd255, 8'd0, 8'd128, 1'b0, 8);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
